// File: rtl/test_sequencer.sv
// Runs N_TESTS testers one after another against a shared DUT, resetting the DUT
// before each test and collecting per-channel fail and timeout verdicts.
module test_sequencer #(
   parameter int N_TESTS    = 4,
   parameter int TIMEOUT    = 1024,
   parameter int RST_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [N_TESTS-1:0] test_stop,
   input  logic [N_TESTS-1:0] test_fail,
   output logic [N_TESTS-1:0] test_start,
   output logic               dut_reset,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [N_TESTS-1:0] fail_mask,
   output logic [N_TESTS-1:0] timeout_mask,
   output logic [3:0]         cur_idx
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [N_TESTS-1:0] LSB_ONE  = N_TESTS'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [7:0]         HOLD_LD  = 8'(RST_CYCLES);
   localparam logic [3:0]         IDX_LAST = 4'(N_TESTS - 1);

   typedef enum logic [2:0] {
      IDLE,
      DUT_RST,
      RUN,
      NEXT,
      DONE
   } state_t;

   state_t             r_state, w_stateNext;
   logic [CNT_W-1:0]   r_cnt, w_cntNext;
   logic [7:0]         r_hold, w_holdNext;
   logic [3:0]         r_curIdx, w_idxNext;
   logic [N_TESTS-1:0] r_failMask, w_failNext;
   logic [N_TESTS-1:0] r_toMask, w_toNext;

   logic [N_TESTS-1:0] w_oneHot;
   logic               w_stopCur;
   logic               w_failCur;

   // Only the current channel's stop/fail bits are ever looked at.
   assign w_oneHot  = LSB_ONE << r_curIdx;
   assign w_stopCur = |(test_stop & w_oneHot);
   assign w_failCur = |(test_fail & w_oneHot);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_hold     <= '0;
         r_curIdx   <= '0;
         r_failMask <= '0;
         r_toMask   <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_cnt      <= w_cntNext;
         r_hold     <= w_holdNext;
         r_curIdx   <= w_idxNext;
         r_failMask <= w_failNext;
         r_toMask   <= w_toNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_holdNext  = r_hold;
      w_idxNext   = r_curIdx;
      w_failNext  = r_failMask;
      w_toNext    = r_toMask;

      unique case (r_state)
         IDLE, DONE: begin
            if (go) begin
               w_stateNext = DUT_RST;
               w_cntNext   = '0;
               w_holdNext  = HOLD_LD;
               w_idxNext   = '0;
               w_failNext  = '0;
               w_toNext    = '0;
            end
         end
         DUT_RST: begin
            if (r_hold <= 8'd1) begin
               w_stateNext = RUN;
               w_cntNext   = '0;
            end else begin
               w_holdNext = r_hold - 8'd1;
            end
         end
         RUN: begin
            // A stop arriving in the last budget cycle still counts as a verdict.
            if (w_stopCur) begin
               w_failNext  = (r_failMask & ~w_oneHot) | (w_failCur ? w_oneHot : '0);
               w_stateNext = NEXT;
            end else if (r_cnt == CNT_LAST) begin
               w_failNext  = r_failMask | w_oneHot;
               w_toNext    = r_toMask | w_oneHot;
               w_stateNext = NEXT;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end
         NEXT: begin
            if (r_curIdx == IDX_LAST) begin
               w_stateNext = DONE;
            end else begin
               w_idxNext   = r_curIdx + 4'd1;
               w_holdNext  = HOLD_LD;
               w_stateNext = DUT_RST;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // IDLE is only reachable through reset, so the DUT stays in reset there until the first RUN.
   assign test_start   = (r_state == RUN) ? w_oneHot : '0;
   assign dut_reset    = (r_state == IDLE) || (r_state == DUT_RST);
   assign busy         = (r_state == DUT_RST) || (r_state == RUN) || (r_state == NEXT);
   assign done         = (r_state == DONE);
   assign pass         = done && (r_failMask == '0);
   assign fail_mask    = r_failMask;
   assign timeout_mask = r_toMask;
   assign cur_idx      = r_curIdx;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: behavioural testers answer test_start, and a
// scoreboard queue holds the expected verdict and start-window length of every test.
module tb_test_sequencer;

   localparam int N  = 4;
   localparam int TO = 16;
   localparam int RC = 1;
   localparam int MAXC = N * (TO + RC + 2) + 20;

   typedef struct {
      int idx;
      int len;
      bit f;
      bit t;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         go;
   logic [N-1:0] test_stop;
   logic [N-1:0] test_fail;
   logic [N-1:0] test_start;
   logic         dut_reset;
   logic         busy;
   logic         done;
   logic         pass;
   logic [N-1:0] fail_mask;
   logic [N-1:0] timeout_mask;
   logic [3:0]   cur_idx;

   int   cfgStop[N];
   bit   cfgFail[N];
   exp_t sbQ[$];
   int   nAsserts = 0;
   int   nFails   = 0;
   bit   wasAborted;

   test_sequencer #(
      .N_TESTS   (N),
      .TIMEOUT   (TO),
      .RST_CYCLES(RC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .go          (go),
      .test_stop   (test_stop),
      .test_fail   (test_fail),
      .test_start  (test_start),
      .dut_reset   (dut_reset),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .fail_mask   (fail_mask),
      .timeout_mask(timeout_mask),
      .cur_idx     (cur_idx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "_start"}, test_start, 0);
      checkOutput({pfx, "_dutReset"}, dut_reset, 1);
      checkOutput({pfx, "_busy"}, busy, 0);
      checkOutput({pfx, "_done"}, done, 0);
      checkOutput({pfx, "_pass"}, pass, 0);
      checkOutput({pfx, "_failMask"}, fail_mask, 0);
      checkOutput({pfx, "_toMask"}, timeout_mask, 0);
      checkOutput({pfx, "_curIdx"}, cur_idx, 0);
   endtask

   // Called at a falling edge with the DUT in IDLE or DONE; runs one full sequence.
   task automatic applyStimulus(input bit strays, input bit goNoise, input int abortIdx,
                                output bit aborted);
      int           runCnt[N];
      bit           inWin[N];
      int           rstCnt;
      bit           sawDone;
      logic [N-1:0] expFail;
      logic [N-1:0] expTo;
      logic [N-1:0] st;
      exp_t         e;
      aborted = 1'b0;
      sawDone = 1'b0;
      rstCnt  = 0;
      expFail = '0;
      expTo   = '0;
      sbQ.delete();
      for (int i = 0; i < N; i++) begin
         runCnt[i] = 0;
         inWin[i]  = 1'b0;
         e.idx = i;
         if (cfgStop[i] >= 1 && cfgStop[i] <= TO) begin
            e.len = cfgStop[i];
            e.t   = 1'b0;
            e.f   = cfgFail[i];
         end else begin
            e.len = TO;
            e.t   = 1'b1;
            e.f   = 1'b1;
         end
         expFail[i] = e.f;
         expTo[i]   = e.t;
         sbQ.push_back(e);
      end

      test_stop = '0;
      test_fail = '0;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      checkOutput("startBusy", busy, 1);
      checkOutput("startCurIdx", cur_idx, 0);
      checkOutput("startFailClr", fail_mask, 0);
      checkOutput("startToClr", timeout_mask, 0);

      for (int cyc = 0; cyc < MAXC; cyc++) begin
         if (done) begin
            sawDone = 1'b1;
            break;
         end
         st = test_start;
         if (st != '0) begin
            checkOutput("runOneHot", st, 32'(1) << cur_idx);
            checkOutput("runDutRst", dut_reset, 0);
         end
         for (int i = 0; i < N; i++) begin
            if (st[i] && !inWin[i]) begin
               inWin[i] = 1'b1;
               checkOutput($sformatf("dutRstLen%0d", i), rstCnt, RC);
               checkOutput($sformatf("order%0d", i), cur_idx, i);
               rstCnt = 0;
            end else if (!st[i] && inWin[i]) begin
               inWin[i] = 1'b0;
               if (sbQ.size() == 0) begin
                  checkOutput("sbEmpty", 1, 0);
               end else begin
                  e = sbQ.pop_front();
                  checkOutput($sformatf("sbIdx%0d", i), i, e.idx);
                  checkOutput($sformatf("window%0d", i), runCnt[i], e.len);
                  checkOutput($sformatf("failBit%0d", i), fail_mask[i], e.f);
                  checkOutput($sformatf("toBit%0d", i), timeout_mask[i], e.t);
                  checkOutput($sformatf("nextBusy%0d", i), busy, 1);
               end
            end
         end
         if (dut_reset && busy) rstCnt++;

         if (abortIdx >= 0 && st[abortIdx] && runCnt[abortIdx] == 3) begin
            test_stop = '0;
            test_fail = '0;
            #2 reset = 1'b0;
            #1 checkResetValues("abort");
            sbQ.delete();
            aborted = 1'b1;
            break;
         end

         for (int i = 0; i < N; i++) begin
            if (st[i]) begin
               test_stop[i] = (cfgStop[i] != 0) && (runCnt[i] == cfgStop[i] - 1);
               test_fail[i] = test_stop[i] ? cfgFail[i] : (strays ? 1'($urandom) : 1'b0);
               runCnt[i]++;
            end else begin
               test_stop[i] = strays ? 1'($urandom) : 1'b0;
               test_fail[i] = strays ? 1'($urandom) : 1'b0;
            end
         end
         go = (goNoise && busy) ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end

      if (aborted) return;
      go = 1'b0;
      checkOutput("reachedDone", sawDone, 1);
      checkOutput("sbDrained", sbQ.size(), 0);
      checkOutput("doneCurIdx", cur_idx, N - 1);
      checkOutput("doneFailMask", fail_mask, expFail);
      checkOutput("doneToMask", timeout_mask, expTo);
      checkOutput("donePass", pass, (expFail == '0) ? 1 : 0);
      for (int k = 0; k < 4; k++) begin
         test_stop = 4'($urandom);
         test_fail = 4'($urandom);
         @(negedge clk);
         checkOutput("holdDone", done, 1);
         checkOutput("holdBusy", busy, 0);
         checkOutput("holdFail", fail_mask, expFail);
         checkOutput("holdTo", timeout_mask, expTo);
         checkOutput("holdPass", pass, (expFail == '0) ? 1 : 0);
      end
      test_stop = '0;
      test_fail = '0;
   endtask

   initial begin
      reset     = 1'b0;
      go        = 1'b0;
      test_stop = '0;
      test_fail = '0;
      #1 checkResetValues("por");
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("idleDutRst", dut_reset, 1);
         checkOutput("idleBusy", busy, 0);
      end

      $display("[TB] all testers stop after 10 cycles, no failures");
      cfgStop = '{10, 10, 10, 10};
      cfgFail = '{0, 0, 0, 0};
      applyStimulus(1'b0, 1'b0, -1, wasAborted);

      $display("[TB] tester 2 fails, stray stops and go noise");
      cfgFail = '{0, 0, 1, 0};
      applyStimulus(1'b1, 1'b1, -1, wasAborted);

      $display("[TB] boundary stop, tester 1 never stops, short test");
      cfgStop = '{TO, 0, 5, 1};
      cfgFail = '{0, 0, 0, 1};
      applyStimulus(1'b1, 1'b0, -1, wasAborted);

      $display("[TB] reset asserted during test 1");
      cfgStop = '{10, 10, 10, 10};
      cfgFail = '{1, 1, 1, 1};
      applyStimulus(1'b0, 1'b0, 1, wasAborted);
      checkOutput("abortTaken", wasAborted, 1);
      @(negedge clk);
      checkResetValues("held");
      reset = 1'b1;
      @(negedge clk);
      checkResetValues("released");

      $display("[TB] restart after abort, mixed verdicts");
      cfgStop = '{3, 7, 12, 20};
      cfgFail = '{1, 0, 1, 0};
      applyStimulus(1'b1, 1'b1, -1, wasAborted);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
